// File: rtl/shift_pkg.sv
// Shared definitions for the serial-to-parallel deserializer: output FSM
// state encoding and the default parallel word width.
package shift_pkg;

  localparam int NDATA_DEFAULT = 128;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/shift_core.sv
// NDATA-wide serial shift stage. Exposes the value the stage will hold after
// the current edge so the completing bit can be captured in the same cycle.
module shift_core
  import shift_pkg::*;
#(
  parameter int NDATA     = NDATA_DEFAULT,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             restart,
  input  logic             din,
  output logic [NDATA-1:0] word
);

  logic [NDATA-1:0] q;
  logic [NDATA-1:0] base;

  // A restart drops the partial word, so the new bit shifts into a clean stage.
  assign base = restart ? '0 : q;

  generate
    if (MSB_FIRST) begin : g_msb
      assign word = {base[NDATA-2:0], din};
    end else begin : g_lsb
      assign word = {din, base[NDATA-1:1]};
    end
  endgenerate

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= word;
    end else if (restart) begin
      q <= '0;
    end
  end

endmodule

// File: rtl/shift_deser.sv
// Serial-to-parallel deserializer: shift stage, bit counter, one-word holding
// register with a valid/ready handshake and a sticky overflow flag.
module shift_deser
  import shift_pkg::*;
#(
  parameter int NDATA     = NDATA_DEFAULT,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     din,
  input  logic                     din_vld,
  input  logic                     sof,
  output logic [NDATA-1:0]         dout,
  output logic                     dout_vld,
  input  logic                     dout_rdy,
  output logic [$clog2(NDATA)-1:0] bit_cnt,
  output logic                     ovf,
  input  logic                     ovf_clr
);

  localparam int CW = $clog2(NDATA);
  localparam logic [CW-1:0] LAST = CW'(NDATA - 1);

  logic [NDATA-1:0] word;
  logic             complete;
  logic             load;
  logic             drop;
  state_t           state;
  state_t           state_next;

  shift_core #(
    .NDATA    (NDATA),
    .MSB_FIRST(MSB_FIRST)
  ) u_core (
    .clk    (clk),
    .rst    (rst),
    .en     (din_vld),
    .restart(sof),
    .din    (din),
    .word   (word)
  );

  // A bit accepted with sof is always bit 0 of a new word, so it cannot complete.
  assign complete = din_vld && !sof && (bit_cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt <= '0;
    end else if (din_vld) begin
      if (sof)           bit_cnt <= CW'(1);
      else if (complete) bit_cnt <= '0;
      else               bit_cnt <= bit_cnt + CW'(1);
    end else if (sof) begin
      bit_cnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    drop       = 1'b0;
    case (state)
      EMPTY: begin
        if (complete) begin
          load       = 1'b1;
          state_next = FULL;
        end
      end
      FULL: begin
        if (complete) begin
          if (dout_rdy) load = 1'b1;
          else          drop = 1'b1;
        end else if (dout_rdy) begin
          state_next = EMPTY;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)       dout <= '0;
    else if (load) dout <= word;
  end

  // A drop in the same cycle as a clear leaves the flag set.
  always_ff @(posedge clk) begin
    if (rst)          ovf <= 1'b0;
    else if (drop)    ovf <= 1'b1;
    else if (ovf_clr) ovf <= 1'b0;
  end

  assign dout_vld = (state == FULL);

endmodule

// File: doc/shift_deser.md
SHIFT_DESER -- requirements
Module: shift_deser

Interface
REQ-001 Parameter NDATA, default 128, SHALL set the parallel word width; legal range 2..1024.
REQ-002 Parameter MSB_FIRST, default 1, SHALL set serial bit order: 1 = first bit received lands in dout[NDATA-1]; 0 = first bit lands in dout[0].
REQ-003 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  SHALL be the reset, synchronous and active-high.
REQ-005 Port din  input  1  SHALL carry serial data, sampled only when din_vld=1.
REQ-006 Port din_vld  input  1  SHALL qualify din; 1 = bit accepted this cycle.
REQ-007 Port sof  input  1  SHALL mark start of frame; it aborts any partial word.
REQ-008 Port dout  output  NDATA  SHALL present the completed parallel word from the holding register.
REQ-009 Port dout_vld  output  1  SHALL indicate that dout holds an unconsumed word.
REQ-010 Port dout_rdy  input  1  SHALL accept the word; transfer occurs when dout_vld=1 and dout_rdy=1.
REQ-011 Port bit_cnt  output  clog2(NDATA)  SHALL report the number of bits held in the partial word.
REQ-012 Port ovf  output  1  SHALL be a sticky flag marking that a completed word was dropped.
REQ-013 Port ovf_clr  input  1  SHALL clear ovf.

Function
REQ-014 The shift stage SHALL accept one bit per cycle with din_vld=1; no backpressure is applied to din.
REQ-015 When MSB_FIRST=1, the shift stage SHALL shift toward the MSB with din entering bit 0; when MSB_FIRST=0, it SHALL shift toward the LSB with din entering bit NDATA-1.
REQ-016 bit_cnt SHALL increment on each accepted bit and wrap from NDATA-1 to 0 on the completing bit.
REQ-017 The completing bit (din_vld=1, bit_cnt=NDATA-1) SHALL move the full word, including that bit, into the holding register at the same edge, so that dout_vld=1 in the next cycle (1-cycle latency).
REQ-018 The output FSM SHALL have two states: EMPTY (dout_vld=0) and FULL (dout_vld=1).
  - EMPTY -> FULL on completion.
  - FULL -> EMPTY on transfer without completion.
  - FULL stays FULL on completion with simultaneous transfer; the new word is loaded.
REQ-019 Completion in FULL without a transfer SHALL drop the new word, keep dout unchanged, and set ovf=1 at that edge.
REQ-020 dout SHALL be stable while dout_vld=1 and no transfer occurs.
REQ-021 sof=1 with din_vld=1 SHALL discard the partial word and accept din as bit 0 of a new word, making bit_cnt=1 (for NDATA=1-legal cases only, not applicable).
REQ-022 sof=1 with din_vld=0 SHALL set bit_cnt=0 and discard the partial word.
REQ-023 sof SHALL NOT affect the holding register or dout_vld.
REQ-024 ovf_clr=1 SHALL clear ovf; if a drop occurs in the same cycle, set SHALL win and ovf=1.
REQ-025 Discarded partial-word bits SHALL never appear on dout.

Reset
REQ-026 rst=1 at a clk edge SHALL set the shift stage=0, bit_cnt=0, dout=0, dout_vld=0 (EMPTY) and ovf=0, overriding all other inputs.
REQ-027 Reset asserted mid-word or while FULL SHALL lose all data; the first accepted bit after reset SHALL be bit 0 of a new word.

Structure
REQ-028 Package shift_pkg SHALL hold the output FSM state encoding (EMPTY=0, FULL=1) and the default NDATA constant.
REQ-029 One sub-module, shift_core, SHALL implement the NDATA-wide shift stage with the direction parameter and shift enable; counter, FSM and flags SHALL reside in shift_deser.

Verification (NDATA=8)
REQ-030 Reset, then with MSB_FIRST=1 send bits 1,0,1,1,0,0,1,0 back-to-back -> dout=8'hB2 and dout_vld=1 one cycle after the 8th bit, with bit_cnt=0.
REQ-031 Same bits with MSB_FIRST=0 -> dout=8'h4D.
REQ-032 Hold dout_rdy=0 and send two full words 8'hB2 then 8'hFF -> dout stays 8'hB2 and ovf=1; pulse ovf_clr -> ovf=0.
REQ-033 Hold dout_rdy=1 and stream 16 continuous bits -> two words delivered and dout_vld never drops between them at completion edges, with ovf=0.
REQ-034 Send 5 bits, then sof with din=1, then 7 more bits -> the word starts with the sof bit, the 5 bits are absent, and bit_cnt sequence is 5 -> 1 -> ... -> 0.
REQ-035 Assert rst while FULL with bit_cnt=3 -> all outputs 0 next cycle; the next 8 bits form a clean word.
